// File: rtl/fp32_pkg.sv
// Shared FP32 constants, flag bit positions and the normalised-stage record.
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Bit positions inside the 5-bit flag vector {invalid, overflow, underflow, inexact, zero}
    localparam int FLG_INVALID   = 4;
    localparam int FLG_OVERFLOW  = 3;
    localparam int FLG_UNDERFLOW = 2;
    localparam int FLG_INEXACT   = 1;
    localparam int FLG_ZERO      = 0;

    // Normalised but not yet rounded product, carried from stage 1 to stage 2
    typedef struct packed {
        logic               sign;
        logic signed [10:0] e;
        logic [22:0]        frac;
        logic               guard;
        logic               sticky;
        logic               zero;
        logic               inf;
        logic               nan;
    } s1_rec_t;

endpackage

// File: rtl/fp32_round_ne.sv
// Round-to-nearest-even of a 23-bit fraction; shared by the multiplier and adder paths.
module fp32_round_ne (
    input  logic [22:0]        frac,
    input  logic               guard,
    input  logic               sticky,
    input  logic signed [10:0] e,
    output logic [22:0]        frac_rnd,
    output logic signed [10:0] e_rnd,
    output logic               inexact
);

    // Increment only above the halfway point, or exactly at it when the fraction is odd
    function automatic logic [23:0] rne_add(input logic [22:0] f, input logic g, input logic s);
        return {1'b0, f} + {23'd0, g & (s | f[0])};
    endfunction

    logic [23:0] sum;

    // A carry out of the fraction means the significand became 2.0: bump the exponent
    always_comb begin
        sum     = rne_add(frac, guard, sticky);
        inexact = guard | sticky;
        if (sum[23]) begin
            frac_rnd = '0;
            e_rnd    = e + 11'sd1;
        end else begin
            frac_rnd = sum[22:0];
            e_rnd    = e;
        end
    end

endmodule

// File: rtl/fp32_mul_round_pack.sv
// FP32 multiplier back end: normalise, round-nearest-even, range/special handling, pack.
module fp32_mul_round_pack
    import fp32_pkg::*;
#(
    parameter int BIAS          = EXP_BIAS,
    parameter int FLUSH_SUBNORM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp_sum,
    input  logic [47:0] in_mant,
    input  logic        in_zero,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    localparam logic signed [10:0] BIAS_S = 11'(BIAS);
    localparam logic signed [10:0] EMAX_S = 11'(EXP_MAX);

    logic               vld_p1;
    s1_rec_t            rec_p1;
    logic               adv_p2;
    logic signed [10:0] e_nrm_p0;
    logic [22:0]        frac_p0;
    logic               guard_p0;
    logic               sticky_p0;
    logic [22:0]        frac_rnd_p1;
    logic signed [10:0] e_rnd_p1;
    logic               inexact_p1;
    logic [31:0]        res_p1;
    logic [4:0]         flg_p1;

    // Stage 2 moves whenever its slot is empty or being drained; stage 1 accepts on the same condition
    always_comb begin
        adv_p2   = !out_valid || out_ready;
        in_ready = rst || !vld_p1 || adv_p2;
    end

    // ---- stage 0 -> 1: normalise so the hidden one sits just above frac ----
    // Pick the exponent and fraction window from the product's leading bit
    always_comb begin
        if (in_mant[47]) begin
            e_nrm_p0  = $signed({2'b00, in_exp_sum}) - BIAS_S + 11'sd1;
            frac_p0   = in_mant[46:24];
            guard_p0  = in_mant[23];
            sticky_p0 = |in_mant[22:0];
        end else begin
            e_nrm_p0  = $signed({2'b00, in_exp_sum}) - BIAS_S;
            frac_p0   = in_mant[45:23];
            guard_p0  = in_mant[22];
            sticky_p0 = |in_mant[21:0];
        end
    end

    // Stage 1 occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage 1 payload, captured on each accepted beat
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            rec_p1.sign   <= in_sign;
            rec_p1.e      <= e_nrm_p0;
            rec_p1.frac   <= frac_p0;
            rec_p1.guard  <= guard_p0;
            rec_p1.sticky <= sticky_p0;
            rec_p1.zero   <= in_zero;
            rec_p1.inf    <= in_inf;
            rec_p1.nan    <= in_nan;
        end
    end

    // ---- stage 1 -> 2: round, classify, pack ----
    fp32_round_ne u_round (
        .frac     (rec_p1.frac),
        .guard    (rec_p1.guard),
        .sticky   (rec_p1.sticky),
        .e        (rec_p1.e),
        .frac_rnd (frac_rnd_p1),
        .e_rnd    (e_rnd_p1),
        .inexact  (inexact_p1)
    );

    // Specials outrank range checks; range checks use the post-rounding exponent
    always_comb begin
        res_p1 = '0;
        flg_p1 = '0;
        if (rec_p1.nan || (rec_p1.inf && rec_p1.zero)) begin
            res_p1              = QNAN;
            flg_p1[FLG_INVALID] = rec_p1.inf && rec_p1.zero;
        end else if (rec_p1.inf) begin
            res_p1 = {rec_p1.sign, 8'hFF, 23'd0};
        end else if (rec_p1.zero) begin
            res_p1           = {rec_p1.sign, 31'd0};
            flg_p1[FLG_ZERO] = 1'b1;
        end else if (e_rnd_p1 >= EMAX_S) begin
            res_p1               = {rec_p1.sign, 8'hFF, 23'd0};
            flg_p1[FLG_OVERFLOW] = 1'b1;
            flg_p1[FLG_INEXACT]  = 1'b1;
        end else if ((FLUSH_SUBNORM == 1) && (e_rnd_p1 <= 11'sd0)) begin
            res_p1                = {rec_p1.sign, 31'd0};
            flg_p1[FLG_UNDERFLOW] = 1'b1;
            flg_p1[FLG_ZERO]      = 1'b1;
            flg_p1[FLG_INEXACT]   = 1'b1;
        end else begin
            res_p1              = {rec_p1.sign, e_rnd_p1[7:0], frac_rnd_p1};
            flg_p1[FLG_INEXACT] = inexact_p1;
        end
    end

    // Output register; holds its contents while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (adv_p2) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_result <= res_p1;
                out_flags  <= flg_p1;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Scoreboard bench for fp32_mul_round_pack: directed cases, backpressure, streaming, reset flush.
module tb_fp32_mul_round_pack;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [8:0]  in_exp_sum = '0;
    logic [47:0] in_mant = '0;
    logic        in_zero = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_nan = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    fp32_mul_round_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp_sum (in_exp_sum),
        .in_mant    (in_mant),
        .in_zero    (in_zero),
        .in_inf     (in_inf),
        .in_nan     (in_nan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: align the leading one to bit 47, round on the low 24 bits by magnitude compare
    function automatic exp_t model(input logic s, input logic [8:0] es, input logic [47:0] m,
                                   input logic z, input logic i, input logic n);
        exp_t        x;
        int          e;
        logic [47:0] k;
        logic [23:0] rest;
        logic [24:0] m25;
        logic        up;
        logic        inx;
        x = '0;
        if (n || (i && z)) begin
            x.r = 32'h7FC0_0000;
            x.f = (i && z) ? 5'b10000 : 5'b00000;
            return x;
        end
        if (i) begin
            x.r = {s, 8'hFF, 23'd0};
            return x;
        end
        if (z) begin
            x.r = {s, 31'd0};
            x.f = 5'b00001;
            return x;
        end
        k    = m[47] ? m : (m << 1);
        e    = int'(es) - 127 + (m[47] ? 1 : 0);
        rest = k[23:0];
        up   = (rest > 24'h800000) || ((rest == 24'h800000) && k[24]);
        inx  = (rest != 24'd0);
        m25  = {1'b0, k[47:24]} + {24'd0, up};
        if (m25[24]) begin
            e   = e + 1;
            m25 = m25 >> 1;
        end
        if (e >= 255) begin
            x.r = {s, 8'hFF, 23'd0};
            x.f = 5'b01010;
        end else if (e <= 0) begin
            x.r = {s, 31'd0};
            x.f = 5'b00111;
        end else begin
            x.r = {s, e[7:0], m25[22:0]};
            x.f = {3'b000, inx, 1'b0};
        end
        return x;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat
    task automatic send(input logic s, input logic [8:0] es, input logic [47:0] m,
                        input logic z, input logic i, input logic n, output int waited);
        int k;
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp_sum = es;
        in_mant    = m;
        in_zero    = z;
        in_inf     = i;
        in_nan     = n;
        sb.push_back(model(s, es, m, z, i, n));
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        waited = k;
        if (k >= 50) chk("accept_timeout", 64'(k), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard consumer; while stalled the held output must already equal the head entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_chk++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_out observed=%h expected=none", out_result);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("result", 64'({out_result, out_flags}), 64'(e));
                end
            end else if (out_valid && sb.size() != 0) begin
                chk("stall_hold", 64'({out_result, out_flags}), 64'(sb[0]));
            end
        end
    end

    initial begin
        int w;
        int stalls;
        logic [47:0] m;
        logic [63:0] r64;
        int sp;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        out_ready = 1'b1;

        // 1.0 * 1.0 with latency check
        send(1'b0, 9'd254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        chk("lat_edge1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2", 64'(out_valid), 64'd1);
        drain();

        // Directed values
        send(1'b0, 9'd254, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b0, 9'd254, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b0, 9'd254, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b1, 9'd254, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b0, 9'd400, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b1, 9'd100, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b0, 9'd254, 48'h4000_0000_0000, 1'b1, 1'b1, 1'b0, w);
        send(1'b1, 9'd254, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, w);
        send(1'b1, 9'd254, 48'h4000_0000_0000, 1'b1, 1'b0, 1'b0, w);
        send(1'b0, 9'd254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b1, w);
        drain();

        // Backpressure: two beats fill the pipe, then in_ready must drop
        out_ready = 1'b0;
        send(1'b0, 9'd254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b0, 9'd255, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        fork
            begin
                send(1'b1, 9'd200, 48'h5555_5555_5555, 1'b0, 1'b0, 1'b0, w);
                send(1'b0, 9'd130, 48'hC000_0080_0001, 1'b0, 1'b0, 1'b0, w);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming at full rate
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            r64 = {$urandom(), $urandom()};
            m = r64[47:0];
            if (m[47:46] == 2'b00) m[46] = 1'b1;
            sp = $urandom_range(0, 19);
            send(r64[63], 9'($urandom_range(0, 510)), m,
                 (sp == 2) || (sp == 3), (sp == 1) || (sp == 3), sp == 0, w);
            stalls += w;
        end
        drain();
        chk("stream_stalls", 64'(stalls), 64'd0);

        // Reset with both stages occupied: nothing may emerge afterwards
        out_ready = 1'b0;
        send(1'b0, 9'd254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        send(1'b1, 9'd254, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, w);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_result", 64'(out_result), 64'd0);
        chk("mid_rst_out_flags", 64'(out_flags), 64'd0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
